// File: rtl/jtag_ir_ctrl_pkg.sv
// Shared definitions for the JTAG instruction register: default IR codes,
// capture pattern and the data-register select type.
package jtag_ir_ctrl_pkg;

   // Default instruction codes (BYPASS defaults to all-ones of IR_LEN in the top).
   localparam int IDCODE_IR_DEF = 'h01;
   localparam int DTMCS_IR_DEF  = 'h10;
   localparam int DMI_IR_DEF    = 'h11;

   // Two LSBs loaded on Capture-IR, as required by IEEE 1149.1.
   localparam logic [1:0] CAPTURE_LSB = 2'b01;

   typedef enum logic [1:0] {
      DR_IDCODE = 2'd0,
      DR_DTMCS  = 2'd1,
      DR_DMI    = 2'd2,
      DR_BYPASS = 2'd3
   } dr_sel_e;

   // One-hot select vector: [0]=IDCODE [1]=DTMCS [2]=DMI [3]=BYPASS.
   function automatic logic [3:0] dr_sel_onehot(input dr_sel_e sel);
      logic [3:0] oh;
      oh = 4'b0000;
      case (sel)
         DR_IDCODE: oh = 4'b0001;
         DR_DTMCS:  oh = 4'b0010;
         DR_DMI:    oh = 4'b0100;
         default:   oh = 4'b1000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/jtag_ir_ctrl_if.sv
// Bundle of TAP strobes, serial data and decode outputs around the IR.
// master = TAP controller side, slave = instruction register side.
interface jtag_ir_ctrl_if #(
   parameter int IR_LEN = 5
);
   // Status width is IR_LEN-2; kept at least 1 bit so IR_LEN=2 still elaborates.
   localparam int ST_W = (IR_LEN > 2) ? IR_LEN - 2 : 1;

   logic              tdi;
   logic              tdo;
   logic              test_logic_rst;
   logic              capture_ir;
   logic              shift_ir;
   logic              update_ir;
   logic [ST_W-1:0]   capture_status;
   logic              priv_lock;
   logic [IR_LEN-1:0] ir_out;
   logic              ir_updated;
   logic              sel_idcode;
   logic              sel_dtmcs;
   logic              sel_dmi;
   logic              sel_bypass;

   modport master (
      output tdi, test_logic_rst, capture_ir, shift_ir, update_ir,
             capture_status, priv_lock,
      input  tdo, ir_out, ir_updated, sel_idcode, sel_dtmcs, sel_dmi, sel_bypass
   );

   modport slave (
      input  tdi, test_logic_rst, capture_ir, shift_ir, update_ir,
             capture_status, priv_lock,
      output tdo, ir_out, ir_updated, sel_idcode, sel_dtmcs, sel_dmi, sel_bypass
   );
endinterface

// File: rtl/jtag_ir_ctrl.sv
// JTAG instruction register: serial shift path, Capture-IR pattern,
// Update-IR latch and registered one-hot decode of the latched code.
module jtag_ir_ctrl
   import jtag_ir_ctrl_pkg::*;
#(
   parameter int IR_LEN    = 5,
   parameter int IDCODE_IR = IDCODE_IR_DEF,
   parameter int DTMCS_IR  = DTMCS_IR_DEF,
   parameter int DMI_IR    = DMI_IR_DEF,
   parameter int BYPASS_IR = (1 << IR_LEN) - 1
) (
   input  logic           clk,
   input  logic           rst_n,
   jtag_ir_ctrl_if.slave  bus
);

   localparam int CODE_LIM = 1 << IR_LEN;
   localparam logic [IR_LEN-1:0] IDCODE_C = IDCODE_IR[IR_LEN-1:0];
   localparam logic [IR_LEN-1:0] DTMCS_C  = DTMCS_IR[IR_LEN-1:0];
   localparam logic [IR_LEN-1:0] DMI_C    = DMI_IR[IR_LEN-1:0];

   // Elaboration-time parameter sanity.
   if (IR_LEN < 2 || IR_LEN > 16) begin : g_bad_len
      $error("jtag_ir_ctrl: IR_LEN must be in 2..16");
   end
   if (IDCODE_IR < 0 || IDCODE_IR >= CODE_LIM || DTMCS_IR < 0 || DTMCS_IR >= CODE_LIM ||
       DMI_IR < 0 || DMI_IR >= CODE_LIM || BYPASS_IR < 0 || BYPASS_IR >= CODE_LIM) begin : g_bad_fit
      $error("jtag_ir_ctrl: an IR code does not fit in IR_LEN bits");
   end
   if (IDCODE_IR == DTMCS_IR || IDCODE_IR == DMI_IR || IDCODE_IR == BYPASS_IR ||
       DTMCS_IR == DMI_IR || DTMCS_IR == BYPASS_IR || DMI_IR == BYPASS_IR) begin : g_bad_dup
      $error("jtag_ir_ctrl: IR codes must be distinct");
   end

   // BYPASS_IR needs no explicit compare: every unrecognised code maps to BYPASS.
   function automatic dr_sel_e decode_ir(input logic [IR_LEN-1:0] code, input logic lock);
      dr_sel_e sel;
      if (code == IDCODE_C)      sel = DR_IDCODE;
      else if (code == DTMCS_C)  sel = DR_DTMCS;
      else if (code == DMI_C)    sel = lock ? DR_BYPASS : DR_DMI;
      else                       sel = DR_BYPASS;
      return sel;
   endfunction

   logic [IR_LEN-1:0] capture_val;
   logic [IR_LEN-1:0] shift_q, shift_d;
   logic [IR_LEN-1:0] ir_q, ir_d;
   logic [3:0]        sel_q, sel_d;
   logic              upd_q, upd_d;

   if (IR_LEN > 2) begin : g_cap_status
      assign capture_val = {bus.capture_status, CAPTURE_LSB};
   end else begin : g_cap_plain
      assign capture_val = CAPTURE_LSB;
   end

   // Next-state: one action per cycle, TLR > shift > capture > update.
   always_comb begin
      shift_d = shift_q;
      ir_d    = ir_q;
      sel_d   = sel_q;
      upd_d   = 1'b0;
      if (bus.test_logic_rst) begin
         shift_d = IDCODE_C;
         ir_d    = IDCODE_C;
         sel_d   = dr_sel_onehot(DR_IDCODE);
      end else if (bus.shift_ir) begin
         shift_d = {bus.tdi, shift_q[IR_LEN-1:1]};
      end else if (bus.capture_ir) begin
         shift_d = capture_val;
      end else if (bus.update_ir) begin
         ir_d  = shift_q;
         sel_d = dr_sel_onehot(decode_ir(shift_q, bus.priv_lock));
         upd_d = 1'b1;
      end
   end

   // State registers; async reset returns everything to the IDCODE instruction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q <= IDCODE_C;
         ir_q    <= IDCODE_C;
         sel_q   <= dr_sel_onehot(DR_IDCODE);
         upd_q   <= 1'b0;
      end else begin
         shift_q <= shift_d;
         ir_q    <= ir_d;
         sel_q   <= sel_d;
         upd_q   <= upd_d;
      end
   end

   assign bus.tdo        = shift_q[0];
   assign bus.ir_out     = ir_q;
   assign bus.ir_updated = upd_q;
   assign bus.sel_idcode = sel_q[0];
   assign bus.sel_dtmcs  = sel_q[1];
   assign bus.sel_dmi    = sel_q[2];
   assign bus.sel_bypass = sel_q[3];

endmodule

// File: tb/tb_jtag_ir_ctrl.sv
// Bench for jtag_ir_ctrl: a 5-bit and an 8-bit instance driven by the same
// strobes, compared every cycle against a bit-queue model, plus literal checks.
module tb_jtag_ir_ctrl;

   logic clk;
   logic rst_n;
   logic tdi, tlr, cap, sh, upd, lock;
   logic [5:0] status;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 0;

   jtag_ir_ctrl_if #(.IR_LEN(5)) if5 ();
   jtag_ir_ctrl_if #(.IR_LEN(8)) if8 ();

   assign if5.tdi = tdi;             assign if8.tdi = tdi;
   assign if5.test_logic_rst = tlr;  assign if8.test_logic_rst = tlr;
   assign if5.capture_ir = cap;      assign if8.capture_ir = cap;
   assign if5.shift_ir = sh;         assign if8.shift_ir = sh;
   assign if5.update_ir = upd;       assign if8.update_ir = upd;
   assign if5.priv_lock = lock;      assign if8.priv_lock = lock;
   assign if5.capture_status = status[2:0];
   assign if8.capture_status = status;

   jtag_ir_ctrl #(.IR_LEN(5)) u5 (.clk(clk), .rst_n(rst_n), .bus(if5));
   jtag_ir_ctrl #(.IR_LEN(8), .BYPASS_IR('hFF)) u8 (.clk(clk), .rst_n(rst_n), .bus(if8));

   initial clk = 0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   // Shift register kept as a queue of bits, element 0 = bit nearest TDO.
   int mlen[2] = '{5, 8};
   bit msh[2][$];
   int mir[2];
   int msel[2];   // 0=IDCODE 1=DTMCS 2=DMI 3=BYPASS
   bit mupd[2];

   function automatic int qval(input int i);
      int v = 0;
      for (int k = 0; k < msh[i].size(); k++) if (msh[i][k]) v += (1 << k);
      return v;
   endfunction

   function automatic int mdecode(input int code, input bit lk);
      if (code == 'h01) return 0;
      if (code == 'h10) return 1;
      if (code == 'h11) return lk ? 3 : 2;
      return 3;
   endfunction

   task automatic model_reset_one(input int i);
      msh[i].delete();
      for (int k = 0; k < mlen[i]; k++) msh[i].push_back(k == 0);
      mir[i] = 'h01; msel[i] = 0; mupd[i] = 0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) model_reset_one(i);
   endtask

   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         mupd[i] = 0;
         if (tlr) model_reset_one(i);
         else if (sh) begin
            void'(msh[i].pop_front());
            msh[i].push_back(tdi);
         end else if (cap) begin
            msh[i].delete();
            msh[i].push_back(1'b1);
            msh[i].push_back(1'b0);
            for (int k = 0; k < mlen[i] - 2; k++) msh[i].push_back(status[k]);
         end else if (upd) begin
            mir[i]  = qval(i);
            msel[i] = mdecode(mir[i], lock);
            mupd[i] = 1;
         end
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic cmp_inst(input int i, input bit d_tdo, input int d_ir,
                           input logic [3:0] d_sel, input bit d_upd);
      string tag;
      tag = (i == 0) ? "ir5" : "ir8";
      chk({tag, ".tdo"}, d_tdo, msh[i][0]);
      chk({tag, ".ir_out"}, d_ir, mir[i]);
      chk({tag, ".sel"}, d_sel, 1 << msel[i]);
      chk({tag, ".ir_updated"}, d_upd, mupd[i]);
      chk({tag, ".onehot"}, $countones(d_sel), 1);
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         cmp_inst(0, if5.tdo, int'(if5.ir_out),
                  {if5.sel_bypass, if5.sel_dmi, if5.sel_dtmcs, if5.sel_idcode}, if5.ir_updated);
         cmp_inst(1, if8.tdo, int'(if8.ir_out),
                  {if8.sel_bypass, if8.sel_dmi, if8.sel_dtmcs, if8.sel_idcode}, if8.ir_updated);
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input bit t_tdi, input bit t_tlr, input bit t_cap,
                      input bit t_sh, input bit t_upd);
      tdi = t_tdi; tlr = t_tlr; cap = t_cap; sh = t_sh; upd = t_upd;
      @(posedge clk);
      #1;
      model_step();
   endtask

   task automatic shift_val(input int v, input int n);
      for (int k = 0; k < n; k++) cyc(((v >> k) & 1) != 0, 0, 0, 1, 0);
   endtask

   initial begin
      logic [4:0] exp_tdo;
      rst_n = 0; tdi = 0; tlr = 0; cap = 0; sh = 0; upd = 0; lock = 0; status = 6'd0;
      model_reset();
      cmp_en = 1;
      #22;
      chk("reset ir_out", int'(if5.ir_out), 'h01);
      chk("reset sel_idcode", if5.sel_idcode, 1);
      chk("reset tdo", if5.tdo, 1);
      chk("reset ir8 ir_out", int'(if8.ir_out), 'h01);
      rst_n = 1;

      // Capture with status 3'b101 -> register 5'b10101, shifted out LSB first.
      status = 6'b000101;
      exp_tdo = 5'b10101;
      cyc(0, 0, 1, 0, 0);
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("capture tdo[%0d]", k), if5.tdo, exp_tdo[k]);
         cyc(0, 0, 0, 1, 0);
      end

      // DMI without lock.
      lock = 0;
      shift_val('h11, 5);
      cyc(0, 0, 0, 0, 1);
      chk("dmi ir_out", int'(if5.ir_out), 'h11);
      chk("dmi sel_dmi", if5.sel_dmi, 1);
      chk("dmi ir_updated", if5.ir_updated, 1);
      cyc(0, 0, 0, 0, 0);
      chk("dmi ir_updated drop", if5.ir_updated, 0);
      lock = 1;
      cyc(0, 0, 0, 0, 0);
      chk("late lock keeps dmi", if5.sel_dmi, 1);

      // DMI with lock -> BYPASS, raw code still visible.
      shift_val('h11, 5);
      cyc(0, 0, 0, 0, 1);
      chk("locked ir_out", int'(if5.ir_out), 'h11);
      chk("locked sel_bypass", if5.sel_bypass, 1);
      chk("locked sel_dmi", if5.sel_dmi, 0);

      // Unknown code -> BYPASS.
      lock = 0;
      shift_val('h07, 5);
      cyc(0, 0, 0, 0, 1);
      chk("unknown ir_out", int'(if5.ir_out), 'h07);
      chk("unknown sel_bypass", if5.sel_bypass, 1);

      // Capture wins over update in the same cycle; update alone then latches capture.
      shift_val('h10, 5);
      cyc(0, 0, 1, 0, 1);
      chk("prio no update", if5.ir_updated, 0);
      chk("prio ir_out held", int'(if5.ir_out), 'h07);
      cyc(0, 0, 0, 0, 1);
      chk("prio captured code", int'(if5.ir_out), 'h15);

      // Test-Logic-Reset beats an active shift.
      shift_val('h03, 2);
      cyc(0, 1, 0, 1, 0);
      chk("tlr ir_out", int'(if5.ir_out), 'h01);
      chk("tlr sel_idcode", if5.sel_idcode, 1);
      chk("tlr tdo", if5.tdo, 1);

      // 8-bit instance: DTMCS.
      shift_val('h10, 8);
      cyc(0, 0, 0, 0, 1);
      chk("ir8 ir_out", int'(if8.ir_out), 'h10);
      chk("ir8 sel_dtmcs", if8.sel_dtmcs, 1);
      chk("ir5 after 8 shifts", int'(if5.ir_out), 'h02);

      // Async reset in the middle of a shift.
      shift_val('h1A, 3);
      #2 rst_n = 0;
      model_reset();
      #1;
      chk("async ir_out", int'(if5.ir_out), 'h01);
      chk("async sel_idcode", if5.sel_idcode, 1);
      chk("async ir8 sel_idcode", if8.sel_idcode, 1);
      #4 rst_n = 1;

      // Random strobe mix, model-checked every cycle.
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 7) == 0) lock = $urandom_range(0, 1) != 0;
         status = 6'($urandom_range(0, 63));
         cyc($urandom_range(0, 1) != 0, $urandom_range(0, 29) == 0,
             $urandom_range(0, 4) == 0, $urandom_range(0, 1) != 0,
             $urandom_range(0, 3) == 0);
      end

      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
